// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the instruction field map, the default word width and the FSM state encoding.
package hazard_pipe_ctrl_pkg;

  localparam int PIPE_INST_W = 19;

  localparam int DEST_HI = 13;
  localparam int DEST_LO = 11;
  localparam int SRC1_HI = 10;
  localparam int SRC1_LO = 8;
  localparam int SRC2_HI = 7;
  localparam int SRC2_LO = 5;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

endpackage

// File: rtl/hazard_pipe_ctrl_stage_reg.sv
// One pipeline stage register that either loads its input or is forced to a bubble (all zeros).
module pipe_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Load-use hazard detection and ID/EX/MEM/WB pipeline registers with stall/flush control.
// A load-use hazard inserts one bubble into EX; a taken branch squashes instead and wins over a stall.
module hazard_pipe_ctrl
  import hazard_pipe_ctrl_pkg::*;
#(
  parameter int INST_W = PIPE_INST_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] id_inst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_reg2_read_source,
  input  logic              branch_taken,
  output logic [INST_W-1:0] ex_inst,
  output logic [INST_W-1:0] mem_inst,
  output logic [INST_W-1:0] wb_inst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              mem_reg_write,
  output logic              wb_reg_write,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_count
);

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [2:0] ex_dest;
  logic [2:0] id_src1;
  logic [2:0] id_src2_eff;
  logic       load_use;
  logic       ex_bubble;

  assign ex_dest     = ex_inst[DEST_HI:DEST_LO];
  assign id_src1     = id_inst[SRC1_HI:SRC1_LO];
  assign id_src2_eff = id_reg2_read_source ? id_inst[SRC1_HI:SRC1_LO] : id_inst[SRC2_HI:SRC2_LO];

  // Register 0 is hardwired, so a load into it can never create a dependency.
  assign load_use = ex_mem_read && (ex_dest != 3'd0) &&
                    ((ex_dest == id_src1) || (ex_dest == id_src2_eff));

  assign stall     = load_use && !branch_taken && !rst;
  assign flush     = branch_taken && !rst;
  assign ex_bubble = stall || flush;

  pipe_stage_reg #(.W(INST_W + 2)) u_ex_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (ex_bubble),
    .d      ({id_inst, id_reg_write, id_mem_read}),
    .q      ({ex_inst, ex_reg_write, ex_mem_read})
  );

  pipe_stage_reg #(.W(INST_W + 1)) u_mem_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (1'b0),
    .d      ({ex_inst, ex_reg_write}),
    .q      ({mem_inst, mem_reg_write})
  );

  pipe_stage_reg #(.W(INST_W + 1)) u_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (1'b0),
    .d      ({mem_inst, mem_reg_write}),
    .q      ({wb_inst, wb_reg_write})
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    state_next = stall ? ST_BUBBLE : ST_RUN;
      ST_BUBBLE: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counter saturates so a long-running profile never reads back a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // EX holds a NOP while in BUBBLE, so a hazard there means the bubble was lost.
  bubble_no_stall: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ST_BUBBLE) |-> !stall);

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl with a 2-bit stall counter to reach saturation quickly.
module tb_hazard_pipe_ctrl;

  localparam int INST_W = 19;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic [INST_W-1:0] id_inst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_reg2_read_source;
  logic              branch_taken;
  logic [INST_W-1:0] ex_inst;
  logic [INST_W-1:0] mem_inst;
  logic [INST_W-1:0] wb_inst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              mem_reg_write;
  logic              wb_reg_write;
  logic              stall;
  logic              flush;
  logic [CNT_W-1:0]  stall_count;

  int tests_run;
  int tests_failed;

  hazard_pipe_ctrl #(.INST_W(INST_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_inst             (id_inst),
    .id_reg_write        (id_reg_write),
    .id_mem_read         (id_mem_read),
    .id_reg2_read_source (id_reg2_read_source),
    .branch_taken        (branch_taken),
    .ex_inst             (ex_inst),
    .mem_inst            (mem_inst),
    .wb_inst             (wb_inst),
    .ex_reg_write        (ex_reg_write),
    .ex_mem_read         (ex_mem_read),
    .mem_reg_write       (mem_reg_write),
    .wb_reg_write        (wb_reg_write),
    .stall               (stall),
    .flush               (flush),
    .stall_count         (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Non-zero opcode and low bits keep real instructions distinguishable from a bubble.
  function automatic logic [INST_W-1:0] mk(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    return {5'b10101, d, s1, s2, 5'b00011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic [INST_W-1:0] inst, input logic rw, input logic mr, input logic r2s);
    id_inst             = inst;
    id_reg_write        = rw;
    id_mem_read         = mr;
    id_reg2_read_source = r2s;
  endtask

  initial begin
    logic [INST_W-1:0] ld;
    logic [INST_W-1:0] use_i;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    branch_taken = 1'b0;
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("rst_ex_inst", 32'(ex_inst), 32'd0);
    check_eq("rst_mem_inst", 32'(mem_inst), 32'd0);
    check_eq("rst_wb_inst", 32'(wb_inst), 32'd0);
    check_eq("rst_ctrls", {28'd0, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write}, 32'd0);
    check_eq("rst_count", 32'(stall_count), 32'd0);
    rst = 1'b0;
    settle();
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    check_eq("post_rst_flush", 32'(flush), 32'd0);

    // Load-use on src1 and bubble propagation
    ld = mk(3'd3, 3'd1, 3'd2);
    set_id(ld, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("ld_in_ex", 32'(ex_inst), 32'(ld));
    check_eq("ld_ex_mem_read", 32'(ex_mem_read), 32'd1);
    use_i = mk(3'd4, 3'd3, 3'd6);
    set_id(use_i, 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("src1_stall", 32'(stall), 32'd1);
    check_eq("src1_flush", 32'(flush), 32'd0);
    tick();
    check_eq("src1_ex_bubble", 32'(ex_inst), 32'd0);
    check_eq("src1_ex_ctrls", {30'd0, ex_reg_write, ex_mem_read}, 32'd0);
    check_eq("src1_ld_in_mem", 32'(mem_inst), 32'(ld));
    check_eq("src1_mem_rw", 32'(mem_reg_write), 32'd1);
    check_eq("src1_count", 32'(stall_count), 32'd1);
    check_eq("bubble_no_stall", 32'(stall), 32'd0);
    tick();
    check_eq("use_in_ex", 32'(ex_inst), 32'(use_i));
    check_eq("bubble_mem_inst", 32'(mem_inst), 32'd0);
    check_eq("bubble_mem_rw", 32'(mem_reg_write), 32'd0);
    check_eq("ld_in_wb", 32'(wb_inst), 32'(ld));
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bubble_wb_inst", 32'(wb_inst), 32'd0);
    check_eq("bubble_wb_rw", 32'(wb_reg_write), 32'd0);
    check_eq("use_in_mem", 32'(mem_inst), 32'(use_i));

    // Hazard coinciding with a taken branch: flush wins
    ld = mk(3'd3, 3'd0, 3'd0);
    set_id(ld, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(mk(3'd5, 3'd3, 3'd1), 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b1;
    settle();
    check_eq("br_flush", 32'(flush), 32'd1);
    check_eq("br_stall", 32'(stall), 32'd0);
    tick();
    branch_taken = 1'b0;
    check_eq("br_ex_bubble", 32'(ex_inst), 32'd0);
    check_eq("br_count", 32'(stall_count), 32'd1);
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Effective src2 selects src1 field
    set_id(mk(3'd5, 3'd0, 3'd0), 1'b1, 1'b1, 1'b0);
    tick();
    set_id(mk(3'd1, 3'd5, 3'd2), 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("r2s1_stall", 32'(stall), 32'd1);
    tick();
    check_eq("r2s1_count", 32'(stall_count), 32'd2);
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Effective src2 selects src2 field
    set_id(mk(3'd5, 3'd0, 3'd0), 1'b1, 1'b1, 1'b0);
    tick();
    set_id(mk(3'd1, 3'd6, 3'd5), 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("r2s0_src2_stall", 32'(stall), 32'd1);
    tick();
    check_eq("r2s0_count", 32'(stall_count), 32'd3);
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Same operands, but src2 field ignored when reading src1 twice
    set_id(mk(3'd5, 3'd0, 3'd0), 1'b1, 1'b1, 1'b0);
    tick();
    set_id(mk(3'd1, 3'd6, 3'd5), 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("r2s1_no_stall", 32'(stall), 32'd0);
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Register 0 destination
    set_id(mk(3'd0, 3'd1, 3'd1), 1'b1, 1'b1, 1'b0);
    tick();
    set_id(mk(3'd2, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("reg0_stall", 32'(stall), 32'd0);
    set_id('0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("reg0_count", 32'(stall_count), 32'd3);

    // Saturation, then reset while in BUBBLE
    ld = mk(3'd4, 3'd0, 3'd0);
    set_id(ld, 1'b1, 1'b1, 1'b0);
    tick();
    use_i = mk(3'd1, 3'd4, 3'd0);
    set_id(use_i, 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("sat_stall", 32'(stall), 32'd1);
    tick();
    check_eq("sat_count", 32'(stall_count), 32'd3);
    rst          = 1'b1;
    branch_taken = 1'b1;
    settle();
    check_eq("rst_over_flush", 32'(flush), 32'd0);
    check_eq("rst_over_stall", 32'(stall), 32'd0);
    tick();
    branch_taken = 1'b0;
    check_eq("rstb_ex_inst", 32'(ex_inst), 32'd0);
    check_eq("rstb_mem_inst", 32'(mem_inst), 32'd0);
    check_eq("rstb_wb_inst", 32'(wb_inst), 32'd0);
    check_eq("rstb_ctrls", {28'd0, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write}, 32'd0);
    check_eq("rstb_count", 32'(stall_count), 32'd0);
    rst = 1'b0;
    settle();
    check_eq("rstb_stall", 32'(stall), 32'd0);
    check_eq("rstb_flush", 32'(flush), 32'd0);
    tick();
    check_eq("rstb_resume_ex", 32'(ex_inst), 32'(use_i));
    check_eq("rstb_resume_count", 32'(stall_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
